// File: rtl/handshake_elastic_fifo.sv
// Elastic valid/ready FIFO stage; ins_ready depends only on registered occupancy.
// Optional zero-latency bypass when empty: define HANDSHAKE_FIFO_BYPASS_EN.
module handshake_elastic_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  empty, full;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FullCnt);
  assign head  = mem_q[rd_ptr_q];

  // rst only gates the visible outputs; state is already held by the async reset.
  assign ins_ready = ~full & ~rst;
  assign pop       = ~empty & outs_ready;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  // Empty with a consumer ready: the token flows straight through and is not stored.
  assign push       = ins_valid & ~full & ~(empty & outs_ready);
  assign outs_valid = (~empty | ins_valid) & ~rst;
  always_comb begin
    outs = '0;
    if (!rst) begin
      if (!empty) begin
        outs = head;
      end else if (ins_valid) begin
        outs = ins;
      end
    end
  end
`else
  assign push       = ins_valid & ~full;
  assign outs_valid = ~empty & ~rst;
  assign outs       = outs_valid ? head : '0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = ins;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt_q <= FullCnt);
  a_cnt_underflow: assert property (@(posedge clk) disable iff (rst)
    (cnt_q == '0) |=> (cnt_q <= CntW'(1)));
  a_ins_stable: assert property (@(posedge clk) disable iff (rst)
    (ins_valid && !ins_ready) |=> $stable(ins));
`endif

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Directed and scoreboarded bench for handshake_elastic_fifo (DEPTH=2 and DEPTH=3 instances).
module tb_handshake_elastic_fifo;

  localparam int unsigned W = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ins_2, outs_2, ins_3, outs_3;
  logic         ins_valid_2, ins_ready_2, outs_valid_2, outs_ready_2;
  logic         ins_valid_3, ins_ready_3, outs_valid_3, outs_ready_3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  handshake_elastic_fifo #(.DATA_WIDTH(W), .DEPTH(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins_2),
    .ins_valid  (ins_valid_2),
    .ins_ready  (ins_ready_2),
    .outs       (outs_2),
    .outs_valid (outs_valid_2),
    .outs_ready (outs_ready_2)
  );

  handshake_elastic_fifo #(.DATA_WIDTH(W), .DEPTH(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins_3),
    .ins_valid  (ins_valid_3),
    .ins_ready  (ins_ready_3),
    .outs       (outs_3),
    .outs_valid (outs_valid_3),
    .outs_ready (outs_ready_3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          q[$];
    logic [W-1:0] nxt;
    int          popped;
    int          cycles;
    bit          hold;
    bit          push_m, pop_m;
    int          exp_data;

    // Reset then idle, with a producer already offering a token.
    rst = 1'b1;
    ins_2 = 20'h13579; ins_valid_2 = 1'b1; outs_ready_2 = 1'b1;
    ins_3 = '0; ins_valid_3 = 1'b0; outs_ready_3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_ins_ready", 32'(ins_ready_2), 32'd0);
      check("rst_outs_valid", 32'(outs_valid_2), 32'd0);
      check("rst_outs", 32'(outs_2), 32'd0);
    end
    rst = 1'b0;
    ins_valid_2 = 1'b0;
    #1;
    check("idle_ins_ready", 32'(ins_ready_2), 32'd1);
    check("idle_outs_valid", 32'(outs_valid_2), 32'd0);
    check("idle_ins_ready3", 32'(ins_ready_3), 32'd1);

    // Single token, one-cycle latency.
    cyc();
    ins_2 = 20'h5A785; ins_valid_2 = 1'b1; outs_ready_2 = 1'b1;
    #1;
    check("single_pre_valid", 32'(outs_valid_2), 32'd0);
    cyc();
    ins_valid_2 = 1'b0;
    check("single_valid", 32'(outs_valid_2), 32'd1);
    check("single_data", 32'(outs_2), 32'h5A785);
    cyc();
    check("single_drained", 32'(outs_valid_2), 32'd0);
    check("single_zero", 32'(outs_2), 32'd0);

    // Fill and back-pressure.
    outs_ready_2 = 1'b0;
    ins_2 = 20'd1; ins_valid_2 = 1'b1;
    cyc();
    check("fill1_ready", 32'(ins_ready_2), 32'd1);
    ins_2 = 20'd2;
    cyc();
    check("fill2_ready", 32'(ins_ready_2), 32'd0);
    check("fill2_head", 32'(outs_2), 32'd1);
    ins_2 = 20'd3;
    cyc();
    check("full_ready", 32'(ins_ready_2), 32'd0);
    check("full_valid", 32'(outs_valid_2), 32'd1);
    check("full_head", 32'(outs_2), 32'd1);
    outs_ready_2 = 1'b1;
    #1;
    check("full_pop_no_comb_ready", 32'(ins_ready_2), 32'd0);
    cyc();
    check("pop1_ready_rises", 32'(ins_ready_2), 32'd1);
    check("pop1_head", 32'(outs_2), 32'd2);
    cyc();
    ins_valid_2 = 1'b0;
    check("pop2_head", 32'(outs_2), 32'd3);
    check("pop2_valid", 32'(outs_valid_2), 32'd1);
    cyc();
    check("fill_drained", 32'(outs_valid_2), 32'd0);

    // Streaming: one token per cycle after the first, no bubbles.
    for (int c = 0; c <= 101; c++) begin
      if (c >= 1 && c <= 100) begin
        check("stream_valid", 32'(outs_valid_2), 32'd1);
        check("stream_data", 32'(outs_2), 32'(c - 1));
      end
      if (c == 101) begin
        check("stream_empty", 32'(outs_valid_2), 32'd0);
      end
      check("stream_ready", 32'(ins_ready_2), 32'd1);
      if (c < 100) begin
        ins_2 = W'(c);
        ins_valid_2 = 1'b1;
      end else begin
        ins_valid_2 = 1'b0;
      end
      outs_ready_2 = 1'b1;
      cyc();
    end

    // Random stalls on DEPTH=3 against a queue model.
    nxt = 20'h100;
    popped = 0;
    cycles = 0;
    hold = 1'b0;
    while (popped < 1000 && cycles < 20000) begin
      if (!hold) begin
        ins_valid_3 = 1'($urandom_range(0, 1));
        ins_3 = nxt;
      end
      outs_ready_3 = 1'($urandom_range(0, 1));
      #1;
      check("rnd_ins_ready", 32'(ins_ready_3), 32'(q.size() != 3));
      check("rnd_outs_valid", 32'(outs_valid_3), 32'(q.size() != 0));
      push_m = ins_valid_3 && (q.size() != 3);
      pop_m  = outs_ready_3 && (q.size() != 0);
      if (pop_m) begin
        exp_data = q.pop_front();
        check("rnd_data", 32'(outs_3), 32'(exp_data));
        popped++;
      end
      if (push_m) begin
        q.push_back(int'(ins_3));
        nxt = nxt + W'(1);
        hold = 1'b0;
      end else begin
        hold = ins_valid_3;
      end
      cyc();
      cycles++;
    end
    check("rnd_tokens_drained", 32'(popped), 32'd1000);
    ins_valid_3 = 1'b0;
    outs_ready_3 = 1'b0;

    // Reset mid-stream with two tokens buffered.
    outs_ready_2 = 1'b0;
    ins_2 = 20'h11111; ins_valid_2 = 1'b1;
    cyc();
    ins_2 = 20'h22222;
    cyc();
    ins_valid_2 = 1'b0;
    check("mid_pre_valid", 32'(outs_valid_2), 32'd1);
    check("mid_pre_head", 32'(outs_2), 32'h11111);
    check("mid_pre_full", 32'(ins_ready_2), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(outs_valid_2), 32'd0);
    check("mid_rst_outs", 32'(outs_2), 32'd0);
    check("mid_rst_ready", 32'(ins_ready_2), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("post_rst_no_stale", 32'(outs_valid_2), 32'd0);
    check("post_rst_ready", 32'(ins_ready_2), 32'd1);
    outs_ready_2 = 1'b1;
    ins_2 = 20'hABCDE; ins_valid_2 = 1'b1;
    cyc();
    ins_valid_2 = 1'b0;
    check("post_rst_valid", 32'(outs_valid_2), 32'd1);
    check("post_rst_data", 32'(outs_2), 32'hABCDE);
    cyc();
    check("post_rst_drained", 32'(outs_valid_2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/handshake_elastic_fifo.md
Name: handshake_elastic_fifo

Overview:
- Elastic FIFO stage for the handshake dataflow netlist.
- Sits directly downstream of constant and arithmetic producers: it takes their outs/outs_valid/outs_ready channel and decouples it from the consumer.
- Breaks the combinational ready path back into the producer.
- Absorbs up to DEPTH tokens of consumer back-pressure without losing throughput.

Parameters:
- DATA_WIDTH, 32, width of the data token.
- DEPTH, 2, number of token slots; legal range 1..16, need not be a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ins  input  DATA_WIDTH  incoming token data.
- ins_valid  input  1  incoming token present.
- ins_ready  output  1  FIFO accepts the token this cycle.
- outs  output  DATA_WIDTH  outgoing token data.
- outs_valid  output  1  outgoing token present.
- outs_ready  input  1  consumer accepts the token this cycle.

Behaviour:
- State:
  - storage array mem[0..DEPTH-1], not reset.
  - wr_ptr and rd_ptr, each ceil(log2(DEPTH)) bits, minimum 1.
  - count, 0..DEPTH, ceil(log2(DEPTH+1)) bits.
- Reset: rst high asynchronously clears wr_ptr, rd_ptr and count to 0.
- Outputs while rst is high: ins_ready=0, outs_valid=0, outs=0.
- Push: ins_valid & ins_ready at a rising edge writes mem[wr_ptr]=ins and advances wr_ptr.
- Pop: outs_valid & outs_ready at a rising edge advances rd_ptr.
- Pointer wrap: a pointer at DEPTH-1 advances to 0 (explicit compare, not modulo-2^n).
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- ins_ready = (count != DEPTH) & ~rst. It depends only on registered state; there is no combinational path from outs_ready to ins_ready.
- outs_valid = (count != 0).
- outs = mem[rd_ptr] when count != 0, else all zeros. Data is deterministic for the checker.
- Latency: a token pushed at edge N is visible on outs after edge N (one cycle, no bypass).
- Throughput: one token per cycle sustained when DEPTH>=2 and the consumer is always ready. DEPTH=1 gives half throughput; this is accepted and documented.
- Full (count==DEPTH): ins_ready=0. A pop in the same cycle does not allow a push that cycle; ins_ready rises the following cycle.
- Empty (count==0): outs_valid=0. A push in the same cycle is not visible until the next cycle (bypass variant excepted).
- Order: strict FIFO; tokens are never dropped or duplicated.
- Producer holding ins_valid with ins_ready=0: no state change.
- Reset mid-operation: all stored tokens are discarded immediately. After rst deasserts, the first rising edge may accept a push.
- Sim-only assertions:
  - count never exceeds DEPTH.
  - count never underflows.
  - ins stays stable while ins_valid & ~ins_ready.

Optional Feature:
- Macro: HANDSHAKE_FIFO_BYPASS_EN.
- Defined:
  - When count==0: outs_valid=ins_valid and outs=ins combinationally.
  - If outs_ready is also high, the token passes with zero latency and is not written.
  - If outs_ready is low, the token is written as a normal push.
  - ins_ready is unchanged (still registered-only).
  - When count!=0, behaviour is identical to the undefined case.
- Undefined: behaviour exactly as in Behaviour; one-cycle minimum latency, outs=0 when empty.

Test Plan:
- Reset then idle: rst high for 3 cycles with ins_valid=1 -> ins_ready=0, outs_valid=0, outs=0 throughout. After release, count=0 and ins_ready=1.
- Single token (DATA_WIDTH=20, DEPTH=2): ins=0x5A785 held valid one cycle, outs_ready=1 -> outs_valid=1 with outs=0x5A785 exactly one cycle later, then outs_valid=0. With bypass defined, it appears in the same cycle.
- Fill and back-pressure: outs_ready=0 and ins=1,2,3 valid on consecutive cycles -> 1 and 2 accepted, ins_ready=0 on the third cycle and 3 held. Raise outs_ready -> outputs 1,2,3 in order, with 3 accepted the cycle after the first pop.
- Streaming: 100 incrementing tokens, ins_valid=outs_ready=1 -> one token per cycle after the first, no bubbles, exact order preserved.
- Random stall / wrap: DEPTH=3, random ins_valid and outs_ready (50%), 1000 tokens -> scoreboard match, pointer wrap exercised, count stays within 0..3, ins_ready never depends combinationally on outs_ready.
- Reset mid-stream: 2 tokens buffered, assert rst asynchronously between edges -> outs_valid drops immediately. After release, no stale token appears and new token 0xABCDE passes correctly.
